cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_cache_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller.
// One-word lines, a single outstanding CPU request, and a single outstanding
// memory transaction. Hit, miss and write-back event counters saturate.
module cache_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int INDEX_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_done,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
    output logic [15:0]       wb_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPARE = 3'd1,
        WB_REQ  = 3'd2,
        WB_WAIT = 3'd3,
        AL_REQ  = 3'd4,
        AL_WAIT = 3'd5
    } state_t;

    state_t state_r, state_nxt;

    // Captured request
    logic              req_we_r;
    logic [ADDR_W-1:0] req_addr_r;
    logic [DATA_W-1:0] req_wdata_r;
    // Set when COMPARE is re-entered after a refill, so the re-check is not
    // counted as a hit.
    logic              refill_r;

    // Line storage
    logic [LINES-1:0]  valid_r;
    logic [LINES-1:0]  dirty_r;
    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES];

    logic [INDEX_W-1:0] idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic               hit_s;

    assign idx_s = req_addr_r[INDEX_W-1:0];
    assign tag_s = req_addr_r[ADDR_W-1:INDEX_W];
    assign hit_s = valid_r[idx_s] && (tag_mem[idx_s] == tag_s);

    // Saturating increment for the event counters.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return v;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (cpu_req && cpu_ready) state_nxt = COMPARE;
                else                      state_nxt = IDLE;
            end
            COMPARE: begin
                if (hit_s)                                 state_nxt = IDLE;
                else if (valid_r[idx_s] && dirty_r[idx_s]) state_nxt = WB_REQ;
                else                                       state_nxt = AL_REQ;
            end
            WB_REQ: begin
                if (mem_ready) state_nxt = WB_WAIT;
                else           state_nxt = WB_REQ;
            end
            WB_WAIT: begin
                if (mem_done) state_nxt = AL_REQ;
                else          state_nxt = WB_WAIT;
            end
            AL_REQ: begin
                if (mem_ready) state_nxt = AL_WAIT;
                else           state_nxt = AL_REQ;
            end
            AL_WAIT: begin
                if (mem_done) state_nxt = COMPARE;
                else          state_nxt = AL_WAIT;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered CPU/memory outputs, request capture and line status bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_ready   <= 1'b1;
            cpu_done    <= 1'b0;
            cpu_rdata   <= {DATA_W{1'b0}};
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            mem_wdata   <= {DATA_W{1'b0}};
            req_we_r    <= 1'b0;
            req_addr_r  <= {ADDR_W{1'b0}};
            req_wdata_r <= {DATA_W{1'b0}};
            refill_r    <= 1'b0;
            valid_r     <= {LINES{1'b0}};
            dirty_r     <= {LINES{1'b0}};
        end else begin
            cpu_done  <= 1'b0;
            cpu_ready <= (state_nxt == IDLE);
            // The request is held only while waiting for mem_ready, so it is a
            // single cycle whenever memory is ready at the request.
            mem_req   <= (state_nxt == WB_REQ) || (state_nxt == AL_REQ);
            if (state_nxt == WB_REQ) begin
                mem_we    <= 1'b1;
                mem_addr  <= {tag_mem[idx_s], idx_s};
                mem_wdata <= data_mem[idx_s];
            end else if (state_nxt == AL_REQ) begin
                mem_we    <= 1'b0;
                mem_addr  <= req_addr_r;
            end else begin
                mem_we    <= mem_we;
            end

            case (state_r)
                IDLE: begin
                    refill_r <= 1'b0;
                    if (cpu_req && cpu_ready) begin
                        req_we_r    <= cpu_we;
                        req_addr_r  <= cpu_addr;
                        req_wdata_r <= cpu_wdata;
                    end else begin
                        req_we_r    <= req_we_r;
                    end
                end
                COMPARE: begin
                    if (hit_s) begin
                        cpu_done <= 1'b1;
                        if (req_we_r) dirty_r[idx_s] <= 1'b1;
                        else          cpu_rdata      <= data_mem[idx_s];
                    end else begin
                        dirty_r <= dirty_r;
                    end
                end
                WB_WAIT: begin
                    if (mem_done) dirty_r[idx_s] <= 1'b0;
                    else          dirty_r        <= dirty_r;
                end
                AL_WAIT: begin
                    if (mem_done) begin
                        valid_r[idx_s] <= 1'b1;
                        dirty_r[idx_s] <= 1'b0;
                        refill_r       <= 1'b1;
                    end else begin
                        refill_r <= refill_r;
                    end
                end
                default: refill_r <= refill_r;
            endcase
        end
    end

    // Event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= 16'd0;
            miss_cnt <= 16'd0;
            wb_cnt   <= 16'd0;
        end else begin
            if (state_r == COMPARE && hit_s && !refill_r) hit_cnt <= sat_inc(hit_cnt);
            else                                          hit_cnt <= hit_cnt;
            if (state_r == COMPARE && !hit_s)             miss_cnt <= sat_inc(miss_cnt);
            else                                          miss_cnt <= miss_cnt;
            if (state_r == WB_REQ && mem_ready)           wb_cnt <= sat_inc(wb_cnt);
            else                                          wb_cnt <= wb_cnt;
        end
    end

    // Tag and data arrays; contents are qualified by valid_r, so no reset.
    always_ff @(posedge clk) begin
        if (state_r == AL_WAIT && mem_done) begin
            tag_mem[idx_s]  <= tag_s;
            data_mem[idx_s] <= mem_rdata;
        end else if (state_r == COMPARE && hit_s && req_we_r) begin
            data_mem[idx_s] <= req_wdata_r;
        end else begin
            data_mem[idx_s] <= data_mem[idx_s];
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios followed by random
// traffic, checked against an abstract cache/memory model kept in the bench.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [15:0] cpu_addr = 16'h0;
    logic [31:0] cpu_wdata = 32'h0;
    logic        cpu_ready, cpu_done;
    logic [31:0] cpu_rdata;
    logic        mem_req, mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready, mem_done;
    logic [31:0] mem_rdata;
    logic [15:0] hit_cnt, miss_cnt, wb_cnt;

    cache_ctrl #(.ADDR_W(16), .DATA_W(32), .INDEX_W(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- memory model (mem[i] = i unless written) ----------------
    logic [31:0] act_mem [logic [15:0]];
    bit          rand_ready = 1'b0;
    int          mem_txn_cnt = 0;
    logic [15:0] last_wb_addr = 16'h0, last_rd_addr = 16'h0;
    logic [31:0] last_wb_data = 32'h0;
    logic [31:0] rd_val;

    function automatic logic [31:0] act_rd(input logic [15:0] a);
        if (act_mem.exists(a)) return act_mem[a];
        return {16'h0, a};
    endfunction

    // A request seen at a falling edge is accepted at the next rising edge;
    // mem_done is presented so the controller samples it 10 edges later.
    initial begin
        mem_ready = 1'b1;
        mem_done  = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mem_req && mem_ready && !rst) begin
                mem_txn_cnt++;
                if (mem_we) begin
                    act_mem[mem_addr] = mem_wdata;
                    last_wb_addr = mem_addr;
                    last_wb_data = mem_wdata;
                    rd_val = $urandom;
                end else begin
                    last_rd_addr = mem_addr;
                    rd_val = act_rd(mem_addr);
                end
                @(posedge clk);
                repeat (9) @(posedge clk);
                #1;
                mem_rdata = rd_val;
                mem_done  = 1'b1;
                @(posedge clk);
                #1;
                mem_done  = 1'b0;
            end
        end
    end

    // ---------------- reference cache model ----------------
    bit          rv [16];
    bit          rdty [16];
    logic [11:0] rtag [16];
    logic [31:0] rdat [16];
    logic [31:0] ref_mem [logic [15:0]];
    int          eh = 0, em = 0, ew = 0;
    int          exp_txn = 0;

    function automatic logic [31:0] ref_rd(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return {16'h0, a};
    endfunction

    function automatic int sat16(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic ref_access(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                              output logic hit, output logic wb, output logic [31:0] rdata);
        int i;
        i   = int'(addr[3:0]);
        hit = rv[i] && (rtag[i] == addr[15:4]);
        wb  = 1'b0;
        if (hit) begin
            eh = sat16(eh);
        end else begin
            em = sat16(em);
            if (rv[i] && rdty[i]) begin
                wb = 1'b1;
                ew = sat16(ew);
                ref_mem[{rtag[i], addr[3:0]}] = rdat[i];
            end
            rv[i]   = 1'b1;
            rdty[i] = 1'b0;
            rtag[i] = addr[15:4];
            rdat[i] = ref_rd(addr);
        end
        if (we) begin
            rdat[i] = wd;
            rdty[i] = 1'b1;
        end
        rdata = rdat[i];
    endtask

    task automatic ref_reset();
        for (int i = 0; i < 16; i++) begin
            rv[i]   = 1'b0;
            rdty[i] = 1'b0;
        end
        eh = 0; em = 0; ew = 0;
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_hit_cnt"},  {16'h0, hit_cnt},  32'(eh));
        check_eq({tag, "_miss_cnt"}, {16'h0, miss_cnt}, 32'(em));
        check_eq({tag, "_wb_cnt"},   {16'h0, wb_cnt},   32'(ew));
    endtask

    // One CPU access with full checking against the model.
    task automatic cpu_op(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                          input bit chk_lat);
        logic h, w;
        logic [31:0] er;
        int lat;
        bit got;
        ref_access(we, addr, wd, h, w, er);
        exp_txn += h ? 0 : (w ? 2 : 1);
        got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = cpu_ready;
        end
        if (!got) check_eq("ready_timeout", 32'd0, 32'd1);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = $urandom;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            got = cpu_done;
        end
        if (!got) check_eq("done_timeout", 32'd0, 32'd1);
        if (chk_lat) check_eq("latency", 32'(lat), h ? 32'd1 : (w ? 32'd24 : 32'd13));
        if (!we) check_eq("rdata", cpu_rdata, er);
        check_counters("op");
        check_eq("mem_txns", 32'(mem_txn_cnt), 32'(exp_txn));
    endtask

    logic        h1, w1;
    logic [31:0] e1;
    int          acc_n, second_acc, done_n;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", {31'h0, cpu_ready}, 32'd1);
        check_eq("rst_done",  {31'h0, cpu_done},  32'd0);
        check_eq("rst_rdata", cpu_rdata, 32'd0);
        check_eq("rst_mem",   {mem_req, mem_we, mem_addr, 14'h0} | {mem_wdata}, 32'd0);
        check_counters("rst");
        rst = 1'b0;

        // Cold read miss, then hit on the same word
        cpu_op(1'b0, 16'h0010, 32'h0, 1'b1);
        check_eq("alloc_addr", {16'h0, last_rd_addr}, 32'h0000_0010);
        cpu_op(1'b0, 16'h0010, 32'h0, 1'b1);

        // Write hit, then conflicting read forces a write-back
        cpu_op(1'b1, 16'h0010, 32'hDEAD_BEEF, 1'b1);
        cpu_op(1'b0, 16'h0020, 32'h0, 1'b1);
        check_eq("wb_addr", {16'h0, last_wb_addr}, 32'h0000_0010);
        check_eq("wb_data", last_wb_data, 32'hDEAD_BEEF);
        check_eq("al_addr", {16'h0, last_rd_addr}, 32'h0000_0020);

        // cpu_req held high through a miss: one acceptance, the next only
        // when cpu_ready comes back
        ref_access(1'b0, 16'h0031, 32'h0, h1, w1, e1);
        ref_access(1'b0, 16'h0031, 32'h0, h1, w1, e1);
        exp_txn += 1;
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0031;
        acc_n = 0; second_acc = -1; done_n = 0;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            if (cpu_req && cpu_ready) begin
                acc_n++;
                if (acc_n == 2) second_acc = c;
            end
            @(posedge clk);
            #1;
            if (acc_n == 2) cpu_req = 1'b0;
            if (cpu_done) done_n++;
        end
        check_eq("hold_acc_n", 32'(acc_n), 32'd2);
        check_eq("hold_2nd_acc", 32'(second_acc), 32'd14);
        check_eq("hold_done_n", 32'(done_n), 32'd2);
        check_eq("hold_rdata", cpu_rdata, e1);
        check_counters("hold");

        // Reset during AL_WAIT abandons the access
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0052;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        exp_txn += 1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_eq("midrst_ready", {31'h0, cpu_ready}, 32'd1);
        check_eq("midrst_memreq", {31'h0, mem_req}, 32'd0);
        ref_reset();
        check_counters("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (cpu_done) done_n++;
        end
        check_eq("midrst_no_done", 32'(done_n), 32'd0);
        check_eq("midrst_txns", 32'(mem_txn_cnt), 32'(exp_txn));
        // Previously cached 0x0020 and the abandoned 0x0052 must both miss
        cpu_op(1'b0, 16'h0020, 32'h0, 1'b1);
        cpu_op(1'b0, 16'h0052, 32'h0, 1'b1);

        // Hit counter saturation
        @(negedge clk);
        force dut.hit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.hit_cnt;
        eh = 65535;
        cpu_op(1'b0, 16'h0052, 32'h0, 1'b1);

        // Random traffic with a stalling memory
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a[15] = 1'b1;
            cpu_op(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_err);
        $fatal(1, "watchdog");
    end

endmodule
